// File: rtl/fifo_flow_ctrl_if.sv
// Bus bundle for fifo_flow_ctrl: write/read requests, thresholds and all status outputs.
// The master side is the producer/consumer pair; the slave side is the FIFO itself.
interface fifo_flow_ctrl_if #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [CNT_WIDTH-1:0]  al_full_th;
  logic [CNT_WIDTH-1:0]  al_empty_th;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [CNT_WIDTH-1:0]  count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  al_full;
  logic                  al_empty;
  logic                  pause;
  logic                  err_fifo;

  modport master (
    output data_in, fifo_wr, fifo_rd, al_full_th, al_empty_th,
    input  data_out, valid_out, count, fifo_empty, fifo_full,
           al_full, al_empty, pause, err_fifo
  );

  modport slave (
    input  data_in, fifo_wr, fifo_rd, al_full_th, al_empty_th,
    output data_out, valid_out, count, fifo_empty, fifo_full,
           al_full, al_empty, pause, err_fifo
  );
endinterface

// File: rtl/fifo_flow_ctrl.sv
// Parametrised synchronous FIFO with almost-full/empty flags and hysteretic pause.
// Define FIFO_ERR_STICKY_EN to make err_fifo hold until reset instead of pulsing.
module fifo_flow_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 4
) (
  input  logic           clk,
  input  logic           RESET_L,
  fifo_flow_ctrl_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  pause;
  logic                  pause_nxt;
  logic                  err_fifo;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  op_rejected;

  // Handshake: a request is accepted at the rising edge when its *_ok term is
  // high; a full FIFO still accepts a write paired with an accepted read.
  always_comb begin
    rd_ok       = bus.fifo_rd & (count != '0);
    wr_ok       = bus.fifo_wr & ((count != FULL_CNT) | rd_ok);
    op_rejected = (bus.fifo_wr & ~wr_ok) | (bus.fifo_rd & ~rd_ok);
  end

  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok) begin
      count_nxt = count + CNT_WIDTH'(1);
    end else if (rd_ok && !wr_ok) begin
      count_nxt = count - CNT_WIDTH'(1);
    end
  end

  // Set wins over clear so misconfigured thresholds still throttle the producer.
  always_comb begin
    pause_nxt = pause;
    if (count_nxt >= bus.al_full_th) begin
      pause_nxt = 1'b1;
    end else if (count_nxt <= bus.al_empty_th) begin
      pause_nxt = 1'b0;
    end
  end

  // Storage has no reset; its contents only matter once written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      pause     <= 1'b0;
      err_fifo  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        data_out <= mem[rd_ptr];
      end
      valid_out <= rd_ok;
      count     <= count_nxt;
      pause     <= pause_nxt;
`ifdef FIFO_ERR_STICKY_EN
      err_fifo  <= err_fifo | op_rejected;
`else
      err_fifo  <= op_rejected;
`endif
    end
  end

  assign bus.data_out   = data_out;
  assign bus.valid_out  = valid_out;
  assign bus.count      = count;
  assign bus.fifo_empty = (count == '0);
  assign bus.fifo_full  = (count == FULL_CNT);
  assign bus.al_full    = (count >= bus.al_full_th);
  assign bus.al_empty   = (count <= bus.al_empty_th);
  assign bus.pause      = pause;
  assign bus.err_fifo   = err_fifo;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed plus random bench for fifo_flow_ctrl against a queue-based reference model.
module tb_fifo_flow_ctrl;

  localparam int DW    = 6;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  // clock / reset
  logic clk = 1'b0;
  logic RESET_L;
  always #5 clk = ~clk;

  fifo_flow_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo_flow_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk     (clk),
    .RESET_L (RESET_L),
    .bus     (bus)
  );

  // scoreboard / reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_pause;
  logic          exp_err;
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ph);
    int n;
    n = exp_q.size();
    chk({ph, ":count"},      32'(bus.count),      32'(n));
    chk({ph, ":fifo_full"},  32'(bus.fifo_full),  32'(n == DEPTH));
    chk({ph, ":fifo_empty"}, 32'(bus.fifo_empty), 32'(n == 0));
    chk({ph, ":al_full"},    32'(bus.al_full),    32'(n >= int'(bus.al_full_th)));
    chk({ph, ":al_empty"},   32'(bus.al_empty),   32'(n <= int'(bus.al_empty_th)));
    chk({ph, ":pause"},      32'(bus.pause),      32'(exp_pause));
    chk({ph, ":err_fifo"},   32'(bus.err_fifo),   32'(exp_err));
    chk({ph, ":valid_out"},  32'(bus.valid_out),  32'(exp_valid));
    chk({ph, ":data_out"},   32'(bus.data_out),   32'(exp_data));
  endtask

  // driver: apply one cycle of requests, then update the model and check
  task automatic step(input string ph, input logic wr, input logic rd, input logic [DW-1:0] d);
    int  n;
    bit  rd_ok, wr_ok, rej;
    bus.fifo_wr = wr;
    bus.fifo_rd = rd;
    bus.data_in = d;
    @(posedge clk);
    #1;
    n     = exp_q.size();
    rd_ok = rd && (n != 0);
    wr_ok = wr && ((n != DEPTH) || rd_ok);
    rej   = (wr && !wr_ok) || (rd && !rd_ok);
    exp_valid = rd_ok;
    if (rd_ok) exp_data = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    n = exp_q.size();
    if (n >= int'(bus.al_full_th))       exp_pause = 1'b1;
    else if (n <= int'(bus.al_empty_th)) exp_pause = 1'b0;
`ifdef FIFO_ERR_STICKY_EN
    exp_err = exp_err | rej;
`else
    exp_err = rej;
`endif
    bus.fifo_wr = 1'b0;
    bus.fifo_rd = 1'b0;
    check_all(ph);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_pause = 1'b0;
    exp_err   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.fifo_wr     = 1'b0;
    bus.fifo_rd     = 1'b0;
    bus.data_in     = '0;
    bus.al_full_th  = CW'(6);
    bus.al_empty_th = CW'(2);
    RESET_L = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    RESET_L = 1'b1;
    check_all("post_reset");

    // fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, DW'(i));
    // overflow attempt, then idle cycle
    step("overflow", 1'b1, 1'b0, 6'h3F);
    step("idle_after_ovf", 1'b0, 1'b0, '0);
    // drain in order
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, '0);
    step("underflow", 1'b0, 1'b1, '0);
    step("idle_after_unf", 1'b0, 1'b0, '0);

    // full + simultaneous read/write
    for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, DW'($urandom_range(0, 63)));
    step("full_rdwr", 1'b1, 1'b1, 6'h2A);
    for (int i = 0; i < 8; i++) step("drain_2a", 1'b0, 1'b1, '0);
    // empty + simultaneous read/write
    step("empty_rdwr", 1'b1, 1'b1, DW'($urandom_range(0, 63)));
    step("idle", 1'b0, 1'b0, '0);

    // pointer wrap at occupancy 3
    step("to3", 1'b1, 1'b0, DW'($urandom_range(0, 63)));
    step("to3", 1'b1, 1'b0, DW'($urandom_range(0, 63)));
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, 1'b1, DW'($urandom_range(0, 63)));

    // random traffic with random thresholds
    for (int k = 0; k < 4; k++) begin
      bus.al_full_th  = CW'($urandom_range(0, DEPTH + 1));
      bus.al_empty_th = CW'($urandom_range(0, DEPTH));
      for (int i = 0; i < 60; i++)
        step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             DW'($urandom_range(0, 63)));
    end

    // drain, build occupancy 5 with an overflow earlier in the run, reset mid-burst
    bus.al_full_th  = CW'(6);
    bus.al_empty_th = CW'(2);
    for (int i = 0; i < DEPTH + 1; i++) step("flush", 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) step("to5", 1'b1, 1'b0, DW'($urandom_range(0, 63)));
    step("rd_at5", 1'b1, 1'b1, DW'($urandom_range(0, 63)));
    #2;
    RESET_L = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    RESET_L = 1'b1;
    step("after_reset", 1'b1, 1'b0, 6'h15);
    step("after_reset_rd", 1'b0, 1'b1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_flow_ctrl.md
Name: fifo_flow_ctrl

Overview:
Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds and a hysteretic pause output for upstream flow control. It is the generalised successor to the fixed 6-bit/8-deep fifo. Width and depth are parameters. Storage is internal, reads are registered, and simultaneous full/empty push-pop is supported. It sits between a producer that honours pause and a consumer that issues fifo_rd.

Parameters:
DATA_WIDTH, 6, width of data_in/data_out
DEPTH, 8, number of entries; must be a power of two, >= 2
ADDR_WIDTH, 3, log2(DEPTH); pointer width
CNT_WIDTH, 4, ADDR_WIDTH+1; occupancy counter width (holds 0..DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
RESET_L  in  1  asynchronous active-low reset
data_in  in  DATA_WIDTH  write data
fifo_wr  in  1  write request
fifo_rd  in  1  read request
al_full_th  in  CNT_WIDTH  almost-full threshold (quasi-static)
al_empty_th  in  CNT_WIDTH  almost-empty threshold (quasi-static)
data_out  out  DATA_WIDTH  registered read data
valid_out  out  1  data_out valid, one-cycle pulse
count  out  CNT_WIDTH  current occupancy
fifo_empty  out  1  count == 0 (combinational from count)
fifo_full  out  1  count == DEPTH
al_full  out  1  count >= al_full_th
al_empty  out  1  count <= al_empty_th
pause  out  1  registered flow-control request to producer
err_fifo  out  1  overflow/underflow indication

Behaviour:
- Reset (async, RESET_L=0): wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, pause=0, err_fifo=0. Storage contents are don't-care. After release: fifo_empty=1, al_empty=1 if al_empty_th>=0.
- Accept rules, evaluated on pre-edge count:
  - rd_ok = fifo_rd & (count != 0).
  - wr_ok = fifo_wr & ((count != DEPTH) | rd_ok).
  - Full with simultaneous rd+wr: both accepted, count unchanged.
  - Empty with simultaneous rd+wr: write accepted, read rejected, no bypass.
- Pointers: wr_ptr/rd_ptr advance by 1 on wr_ok/rd_ok. They wrap naturally modulo DEPTH.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Never exceeds DEPTH and never goes below 0.
- Read latency: on rd_ok, mem[rd_ptr] loads into data_out at that edge and valid_out=1 for the following cycle. Without rd_ok, valid_out=0 and data_out holds its last value.
- Errors: err_fifo=1 for one cycle (registered) after a fifo_wr rejected because full, or a fifo_rd rejected because empty. Rejected operations change no state.
- pause, registered, computed from the next count (count_nxt):
  - Set when count_nxt >= al_full_th.
  - Clear when count_nxt <= al_empty_th.
  - Hold otherwise (hysteresis).
  - If both conditions are true (misconfigured thresholds), set wins.
- Flags fifo_empty, fifo_full, al_full and al_empty are combinational from the registered count and thresholds.
- Reset mid-operation: all state clears immediately and asynchronously, and any in-flight valid_out is dropped.

Optional Feature:
- Macro: FIFO_ERR_STICKY_EN.
- Defined: err_fifo is sticky. Once set by an overflow/underflow it stays 1 until RESET_L is asserted.
- Undefined: err_fifo is the one-cycle pulse described above.
- Both builds: rejected-operation behaviour is unchanged.

Test Plan:
- Reset, then 8 writes of 0x01..0x08 (DEPTH=8, al_full_th=6, al_empty_th=2) -> count 8, fifo_full=1, pause rises the cycle count reaches 6, no err_fifo.
- From full, 9th write 0x3F -> err_fifo=1 one cycle, count stays 8; subsequent 8 reads return 0x01..0x08, each with valid_out the cycle after fifo_rd.
- Drain: pause stays 1 through count 5,4,3 and clears when count reaches 2; fifo_empty=1 at count 0. A further read gives err_fifo=1 and valid_out=0.
- Full + simultaneous rd/wr of 0x2A -> count stays 8, oldest entry read out, no error; 0x2A emerges 8 reads later. Empty + simultaneous rd/wr -> count=1, err_fifo=1, valid_out=0.
- Pointer wrap: 20 interleaved write/read pairs at count 3 -> data order preserved across wrap, count constant 3.
- Assert RESET_L low mid-burst at count 5 -> all outputs reset immediately, no clock edge required. With FIFO_ERR_STICKY_EN, err_fifo from an earlier overflow persists until this reset.
